// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg: shared constants, entry type and width helper for the fetch unit
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int                INST_W   = 32;
  localparam int                XLEN_DEF = 32;
  localparam int                PC_STEP  = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_prefetch_unit_if: imem request/response, redirect and decode handshakes
// Rev 1.0
// ============================================================================
interface fetch_prefetch_unit_if
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              imem_req_valid;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic [XLEN-1:0]   id_pc;
  logic              id_ready;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo: synchronous prefetch queue; flush beats push and pop
// Rev 1.0
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  entry_t                din_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o,
  output entry_t                head_o
);
  localparam int PTR_W = clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end
endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_prefetch_unit: pipelined instruction fetch with prefetch queue and
// redirect squashing. FETCH_BYPASS_EN forwards a response to decode when idle.
// Rev 1.0
// ============================================================================
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_prefetch_unit_if.master bus
);
  localparam int CNT_W = clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop, req_fire, rsp_keep, bypass;
  entry_t           head, rsp_entry;

  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (({1'b0, count} + {1'b0, inflight_q}) < (CNT_W+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_keep  = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
  assign rsp_entry = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_keep && !(bypass && bus.id_ready);
  assign pop  = !empty && bus.id_ready && !bus.redirect_valid;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .din_i   (rsp_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  always_comb begin
    bus.id_valid = !empty;
    bus.id_inst  = empty ? NOP_INST : head.inst;
    bus.id_pc    = empty ? '0 : head.pc;
    if (bypass) begin
      bus.id_valid = 1'b1;
      bus.id_inst  = bus.imem_rsp_data;
      bus.id_pc    = rsp_pc_q;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      inflight_d = inflight_d + CNT_W'(1);
    end
    if (bus.imem_rsp_valid) begin
      inflight_d = inflight_d - CNT_W'(1);
      if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      else                  rsp_pc_d   = rsp_pc_q + XLEN'(PC_STEP);
    end
    // inflight already counts stale requests, so every survivor becomes stale
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
      drop_cnt_d = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) assert (!full);
  end
endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// tb_fetch_prefetch_unit: directed vector table plus redirect/reset corner sequences
// against an in-order variable-latency instruction memory model.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_prefetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rdy;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_id_valid;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_id_inst;
  } vec_t;

  vec_t        vt [10];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] req_log [$];
  logic [31:0] dlv_pc  [$];
  logic [31:0] dlv_inst[$];
  logic        s_req_valid, s_id_valid;
  logic [31:0] s_req_addr, s_id_pc, s_id_inst;

  function automatic logic [31:0] minst(input logic [31:0] a);
    return 32'h00100093 + (a << 18);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, sample outputs, then log handshakes.
  task automatic step(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    cyc++;
    rst                = r;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.id_ready       = rdy;
    if (r) begin
      mq_addr.delete();
      mq_due.delete();
    end
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = minst(mq_addr[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_id_valid  = bus.id_valid;
    s_id_pc     = bus.id_pc;
    s_id_inst   = bus.id_inst;
    if (s_req_valid && bus.imem_req_ready) begin
      mq_addr.push_back(s_req_addr);
      mq_due.push_back(cyc + lat);
      req_log.push_back(s_req_addr);
    end
    if (bus.imem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (s_id_valid && rdy && !redir && !r) begin
      dlv_pc.push_back(s_id_pc);
      dlv_inst.push_back(s_id_inst);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    req_log.delete();
    dlv_pc.delete();
    dlv_inst.delete();
  endtask

  task automatic run_until(input int n, input string name);
    int budget;
    budget = 60;
    while (dlv_pc.size() < n && budget > 0) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      budget--;
    end
    chk(name, 32'(dlv_pc.size() >= n), 32'd1);
  endtask

  task automatic chk_stream(input int n0, input logic [31:0] base, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      if (n0 + i < dlv_pc.size()) begin
        chk({name, "_pc"},   dlv_pc[n0+i],   base + 32'(4*i));
        chk({name, "_inst"}, dlv_inst[n0+i], minst(base + 32'(4*i)));
      end
    end
  endtask

  initial begin
    int n0;
    int hits;

    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;

    for (int k = 0; k < 10; k++) begin
      vt[k].rdy           = 1'b1;
      vt[k].exp_req_valid = 1'b1;
      vt[k].exp_req_addr  = 32'(4*k);
      vt[k].exp_id_valid  = (k >= 2 - BYP);
      vt[k].exp_id_pc     = vt[k].exp_id_valid ? 32'(4*(k-2+BYP)) : 32'h0;
      vt[k].exp_id_inst   = vt[k].exp_id_valid ? minst(vt[k].exp_id_pc) : NOP_INST;
    end

    // Reset state
    lat = 1;
    do_reset();
    chk("rst_req_valid", 32'(s_req_valid), 32'd0);
    chk("rst_id_valid",  32'(s_id_valid),  32'd0);
    chk("rst_id_inst",   s_id_inst,        NOP_INST);
    chk("rst_id_pc",     s_id_pc,          32'h0);

    // Streaming with a 1-cycle memory
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, vt[k].rdy);
      chk($sformatf("vec%0d_req_valid", k), 32'(s_req_valid), 32'(vt[k].exp_req_valid));
      chk($sformatf("vec%0d_req_addr", k),  s_req_addr,       vt[k].exp_req_addr);
      chk($sformatf("vec%0d_id_valid", k),  32'(s_id_valid),  32'(vt[k].exp_id_valid));
      chk($sformatf("vec%0d_id_pc", k),     s_id_pc,          vt[k].exp_id_pc);
      chk($sformatf("vec%0d_id_inst", k),   s_id_inst,        vt[k].exp_id_inst);
    end

    // Decode stalled: capacity limit, then in-order drain
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_accepted",  32'(req_log.size()), 32'(DEPTH));
    chk("stall_req_valid", 32'(s_req_valid),    32'd0);
    chk("stall_id_valid",  32'(s_id_valid),     32'd1);
    run_until(6, "stall_drain_timeout");
    chk_stream(0, 32'h0, 6, "stall_drain");

    // 3-cycle memory, redirect with three requests outstanding
    lat = 3;
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    chk("redir3_req_valid", 32'(s_req_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir3_next_req_valid", 32'(s_req_valid), 32'd1);
    chk("redir3_next_req_addr",  s_req_addr,       32'h100);
    chk("redir3_id_valid",       32'(s_id_valid),  32'd0);
    run_until(4, "redir3_timeout");
    chk_stream(0, 32'h100, 4, "redir3");

    // Redirect together with a response and a decode pop
    lat = 2;
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    chk("redir_pop_id_valid_before", 32'(s_id_valid),  32'd1);
    chk("redir_pop_req_valid",       32'(s_req_valid), 32'd0);
    n0 = dlv_pc.size();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_pop_id_valid_after", 32'(s_id_valid),  32'd0);
    chk("redir_pop_next_req_valid", 32'(s_req_valid), 32'd1);
    chk("redir_pop_next_req_addr",  s_req_addr,       32'h40);
    run_until(n0 + 4, "redir_pop_timeout");
    chk_stream(n0, 32'h40, 4, "redir_pop");

    // Back-to-back redirects: the second target wins
    lat = 3;
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    chk("b2b_first_req_valid", 32'(s_req_valid), 32'd0);
    step(1'b0, 1'b1, 32'h300, 1'b1);
    chk("b2b_second_req_valid", 32'(s_req_valid), 32'd0);
    n0 = dlv_pc.size();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("b2b_next_req_addr", s_req_addr, 32'h300);
    run_until(n0 + 4, "b2b_timeout");
    chk_stream(n0, 32'h300, 4, "b2b");
    hits = 0;
    foreach (req_log[i]) if (req_log[i][31:8] == 24'h000002) hits++;
    chk("b2b_no_0x200_request", 32'(hits), 32'd0);

    // Reset with a non-empty queue
    lat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("midrst_queue_busy", 32'(s_id_valid), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("midrst_req_valid", 32'(s_req_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("midrst_id_valid",  32'(s_id_valid),  32'd0);
    chk("midrst_id_inst",   s_id_inst,        NOP_INST);
    chk("midrst_id_pc",     s_id_pc,          32'h0);
    chk("midrst_req_valid_after", 32'(s_req_valid), 32'd1);
    chk("midrst_req_addr",  s_req_addr,       RST_PC);
    n0 = dlv_pc.size();
    run_until(n0 + 3, "midrst_timeout");
    chk_stream(n0, RST_PC, 3, "midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
